// File: rtl/pdu_ctrl.sv
// pdu_ctrl: debug controller gating CPU execution (halt/step/run with breakpoint)
// and servicing debug register reads while halted.
module pdu_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        step,
  input  logic        bp_en,
  input  logic [31:0] bp_addr,
  input  logic [31:0] current_pc,
  output logic        cpu_en,
  input  logic        rd_valid,
  input  logic [31:0] rd_addr,
  output logic        rd_ready,
  output logic [31:0] cpu_check_addr,
  input  logic [31:0] cpu_check_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  input  logic        rsp_ready,
  output logic        halted,
  output logic        bp_hit,
  output logic [31:0] instr_cnt
);
  typedef enum logic [2:0] {HALT, STEP, RUN, RD_ADDR, RD_RSP} state_t;
  state_t      state_q, state_d;
  logic        bp_skip_q, bp_skip_d, bp_hit_q, bp_hit_d, rsp_valid_q, rsp_valid_d;
  logic [31:0] cpu_check_addr_q, cpu_check_addr_d, rsp_data_q, rsp_data_d;
  logic [31:0] instr_cnt_q, instr_cnt_d;
  logic        bp_match;
  // bp_skip lets the instruction sitting on the breakpoint run once when resuming from it
  assign bp_match = bp_en && (current_pc == bp_addr) && !bp_skip_q;
  assign cpu_en   = (state_q == STEP) || (state_q == RUN && run && !bp_match);
  always_comb begin
    state_d          = state_q;
    bp_skip_d        = bp_skip_q;
    bp_hit_d         = bp_hit_q;
    rsp_valid_d      = rsp_valid_q;
    rsp_data_d       = rsp_data_q;
    cpu_check_addr_d = cpu_check_addr_q;
    instr_cnt_d      = instr_cnt_q + {31'd0, cpu_en};
    case (state_q)
      HALT: begin
        if (rd_valid) begin
          state_d          = RD_ADDR;
          cpu_check_addr_d = rd_addr;
        end else if (step) begin
          state_d = STEP;
        end else if (run) begin
          state_d   = RUN;
          bp_skip_d = 1'b1;
          bp_hit_d  = 1'b0;
        end
      end
      STEP: state_d = HALT;
      RUN: begin
        if (cpu_en) bp_skip_d = 1'b0;
        if (bp_match) bp_hit_d = 1'b1;
        if (bp_match || !run) state_d = HALT;
      end
      RD_ADDR: begin
        state_d     = RD_RSP;
        rsp_data_d  = cpu_check_data;
        rsp_valid_d = 1'b1;
      end
      RD_RSP: begin
        if (rsp_ready) begin
          state_d     = HALT;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = HALT;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= HALT;
      bp_skip_q        <= 1'b0;
      bp_hit_q         <= 1'b0;
      rsp_valid_q      <= 1'b0;
      rsp_data_q       <= 32'd0;
      cpu_check_addr_q <= 32'd0;
      instr_cnt_q      <= 32'd0;
    end else begin
      state_q          <= state_d;
      bp_skip_q        <= bp_skip_d;
      bp_hit_q         <= bp_hit_d;
      rsp_valid_q      <= rsp_valid_d;
      rsp_data_q       <= rsp_data_d;
      cpu_check_addr_q <= cpu_check_addr_d;
      instr_cnt_q      <= instr_cnt_d;
    end
  end
  assign rd_ready       = (state_q == HALT);
  assign halted         = (state_q == HALT);
  assign bp_hit         = bp_hit_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;
  assign cpu_check_addr = cpu_check_addr_q;
  assign instr_cnt      = instr_cnt_q;
endmodule

// File: tb/tb_pdu_ctrl.sv
// tb_pdu_ctrl: table-driven read vectors with a response scoreboard, plus
// hand-written step, breakpoint, counter-wrap and reset-abort sequences.
module tb_pdu_ctrl;
  logic        clk = 1'b0, rst = 1'b0, run = 1'b0, step = 1'b0, bp_en = 1'b0;
  logic        rd_valid = 1'b0, rsp_ready = 1'b0;
  logic [31:0] bp_addr = 32'd0, rd_addr = 32'd0, current_pc = 32'd0;
  logic        cpu_en, rd_ready, rsp_valid, halted, bp_hit;
  logic [31:0] cpu_check_addr, cpu_check_data, rsp_data, instr_cnt;
  int          pass_cnt = 0, chk_cnt = 0, en_cnt = 0;
  logic [31:0] sb[$];

  typedef struct {
    logic [31:0] addr;
    int          hold;
    logic        with_step;
    logic [31:0] exp;
  } rd_vec_t;
  rd_vec_t vecs[4];

  pdu_ctrl dut (
    .clk(clk), .rst(rst), .run(run), .step(step), .bp_en(bp_en), .bp_addr(bp_addr),
    .current_pc(current_pc), .cpu_en(cpu_en), .rd_valid(rd_valid), .rd_addr(rd_addr),
    .rd_ready(rd_ready), .cpu_check_addr(cpu_check_addr), .cpu_check_data(cpu_check_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready), .halted(halted),
    .bp_hit(bp_hit), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  // CPU model: PC advances by 4 on every enabled cycle; debug bus is a fixed function of address
  always @(posedge clk or negedge rst)
    if (!rst) current_pc <= 32'd0;
    else if (cpu_en) current_pc <= current_pc + 32'd4;
  always @(posedge clk) if (cpu_en) en_cnt <= en_cnt + 1;
  assign cpu_check_data = (cpu_check_addr == 32'h0000_1005) ? 32'hDEAD_BEEF
                        : {cpu_check_addr[15:0], ~cpu_check_addr[15:0]};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_step();
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    chk("step_cpu_en_hi", cpu_en, 1);
    chk("step_not_halted", halted, 0);
    @(negedge clk);
    chk("step_cpu_en_lo", cpu_en, 0);
    chk("step_halted", halted, 1);
  endtask

  task automatic do_read(input rd_vec_t v);
    int e0;
    logic [31:0] d;
    e0 = en_cnt;
    chk("rd_ready_halt", rd_ready, 1);
    rd_valid  = 1'b1;
    rd_addr   = v.addr;
    step      = v.with_step;
    rsp_ready = (v.hold == 0);
    sb.push_back(v.exp);
    @(negedge clk);
    rd_valid = 1'b0;
    step     = 1'b0;
    rd_addr  = 32'hFFFF_FFFF;
    chk("rd_check_addr", cpu_check_addr, v.addr);
    chk("rd_valid_early", rsp_valid, 0);
    chk("rd_ready_busy", rd_ready, 0);
    @(negedge clk);
    chk("rd_latency_valid", rsp_valid, 1);
    d = (sb.size() > 0) ? sb.pop_front() : 32'hxxxx_xxxx;
    chk("rd_data", rsp_data, d);
    for (int i = 1; i < v.hold; i++) begin
      @(negedge clk);
      chk("rd_hold_valid", rsp_valid, 1);
      chk("rd_hold_data", rsp_data, d);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rd_valid_clear", rsp_valid, 0);
    chk("rd_back_halt", halted, 1);
    chk("rd_addr_held", cpu_check_addr, v.addr);
    chk("rd_no_cpu_en", en_cnt - e0, 0);
  endtask

  initial begin
    int e;
    vecs[0] = '{32'h0000_1005, 3, 1'b0, 32'hDEAD_BEEF};
    vecs[1] = '{32'h0000_0010, 0, 1'b0, 32'h0010_FFEF};
    vecs[2] = '{32'hABCD_1234, 1, 1'b1, 32'h1234_EDCB};
    vecs[3] = '{32'h0000_0000, 2, 1'b1, 32'h0000_FFFF};

    repeat (3) @(negedge clk);
    chk("rst_halted", halted, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rel_halted", halted, 1);
    chk("rel_cpu_en", cpu_en, 0);
    chk("rel_rsp_valid", rsp_valid, 0);
    chk("rel_rsp_data", rsp_data, 0);
    chk("rel_check_addr", cpu_check_addr, 0);
    chk("rel_bp_hit", bp_hit, 0);
    chk("rel_instr_cnt", instr_cnt, 0);

    do_step();
    chk("step_instr_cnt", instr_cnt, 1);

    // breakpoint at 0xC from PC 0, then resume past it
    do_reset();
    bp_en   = 1'b1;
    bp_addr = 32'h0000_000C;
    e       = en_cnt;
    run     = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 20 && !halted; i++) @(negedge clk);
    run = 1'b0;
    chk("bp_halted", halted, 1);
    chk("bp_en_cycles", en_cnt - e, 3);
    chk("bp_pc", current_pc, 32'h0000_000C);
    chk("bp_hit_set", bp_hit, 1);
    chk("bp_instr_cnt", instr_cnt, 3);
    run = 1'b1;
    @(negedge clk);
    chk("rerun_bp_hit_clr", bp_hit, 0);
    chk("rerun_exec_bp", cpu_en, 1);
    @(negedge clk);
    chk("rerun_pc", current_pc, 32'h0000_0010);
    run = 1'b0;
    #1;
    chk("stop_cpu_en", cpu_en, 0);
    @(negedge clk);
    chk("stop_halted", halted, 1);
    chk("stop_bp_hit", bp_hit, 0);
    chk("stop_instr_cnt", instr_cnt, 4);
    chk("stop_pc", current_pc, 32'h0000_0010);
    bp_en = 1'b0;

    foreach (vecs[i]) do_read(vecs[i]);
    chk("sb_empty", sb.size(), 0);

    force dut.instr_cnt_q = 32'hFFFF_FFFE;
    #1 release dut.instr_cnt_q;
    @(negedge clk);
    do_step();
    chk("wrap_max", instr_cnt, 32'hFFFF_FFFF);
    do_step();
    chk("wrap_zero", instr_cnt, 32'h0000_0000);

    // reset while free-running
    run = 1'b1;
    repeat (3) @(negedge clk);
    chk("run_cpu_en", cpu_en, 1);
    rst = 1'b0;
    #1;
    chk("rstrun_cpu_en", cpu_en, 0);
    chk("rstrun_instr_cnt", instr_cnt, 0);
    run = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    e = en_cnt;
    repeat (2) @(negedge clk);
    chk("rstrun_no_pulse", en_cnt - e, 0);
    chk("rstrun_halted", halted, 1);

    // reset while in RD_ADDR
    rd_valid = 1'b1;
    rd_addr  = 32'h0000_2222;
    @(negedge clk);
    rd_valid = 1'b0;
    chk("rstrd_in_rd", halted, 0);
    rst = 1'b0;
    #1;
    chk("rstrd_halted", halted, 1);
    chk("rstrd_check_addr", cpu_check_addr, 0);
    chk("rstrd_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rstrd_no_rsp", rsp_valid, 0);
    end
    chk("rstrd_end_halted", halted, 1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
